// File: rtl/io_timer_sched.sv
// io_timer_sched: four-channel deadline timer with a shared round-robin comparator and an IO register window
module io_timer_sched #(
  parameter logic [15:0] CAddrBase = 16'h0000
) (
  input  logic        AClkH,
  input  logic        AResetHN,
  input  logic        AClkHEn,
  input  logic [15:0] AIoAddr,
  input  logic [3:0]  AIoWrSize,
  input  logic [3:0]  AIoRdSize,
  input  logic [63:0] AIoMosi,
  output logic [63:0] AIoMiso,
  output logic        AIoAddrAck,
  output logic        AIoAddrErr,
  input  logic        ASync1M,
  input  logic        ASync1K,
  output logic        AIrq,
  output logic [7:0]  ATest
);
  logic [5:0]        ctrl_q, ctrl_d;
  logic [3:0]        irqen_q, irqen_d;
  logic [3:0][15:0]  dl_q, dl_d;
  logic [3:0]        armed_q, armed_d;
  logic [3:0]        exp_q, exp_d;
  logic [15:0]       now_q, now_d;
  logic [1:0]        scan_q, scan_d;
  logic              irq_q, irq_d;
  logic [15:0]       off, rd16, diff;
  logic [3:0]        sz, hit_v, dl_we, clr;
  logic              in_win, we, tick, hit;
  logic              unused_ok;
  assign unused_ok = ^AIoMosi[63:16];
  // address decode and zero-latency read mux
  always_comb begin
    off        = AIoAddr - CAddrBase;
    sz         = AIoWrSize | AIoRdSize;
    in_win     = off <= 16'd8;
    AIoAddrAck = in_win & ((off <= 16'd2 & sz == 4'b0001) | (off >= 16'd4 & sz == 4'b0010));
    AIoAddrErr = in_win & |sz & ~AIoAddrAck;
    we         = AIoAddrAck & |AIoWrSize & AClkHEn;
    rd16       = off == 16'd0 ? {10'b0, ctrl_q} :
                 off == 16'd1 ? {12'b0, irqen_q} :
                 off == 16'd2 ? {8'b0, armed_q, exp_q} :
                 off == 16'd8 ? now_q : dl_q[off[1:0]];
    AIoMiso    = (AIoAddrAck & |AIoRdSize) ? {48'b0, rd16} : 64'b0;
  end
  // tick source, shared comparator and per-channel next state (write beats hit, hit beats clear)
  always_comb begin
    tick    = AClkHEn & (ctrl_q[5:4] == 2'b11 | (ctrl_q[5:4] == 2'b10 & ASync1M) | (ctrl_q[5:4] == 2'b01 & ASync1K));
    diff    = now_q - dl_q[scan_q];
    hit     = AClkHEn & ctrl_q[scan_q] & armed_q[scan_q] & ~diff[15];
    ctrl_d  = (we & off == 16'd0) ? AIoMosi[5:0] : ctrl_q;
    irqen_d = (we & off == 16'd1) ? AIoMosi[3:0] : irqen_q;
    now_d   = ctrl_q[5:4] == 2'b00 ? 16'd0 : now_q + {15'b0, tick};
    scan_d  = scan_q + 2'd1;
    irq_d   = |(exp_q & irqen_q);
    for (int i = 0; i < 4; i++) begin
      hit_v[i]   = hit & scan_q == 2'(i);
      dl_we[i]   = we & off == 16'(4 + i);
      clr[i]     = we & off == 16'd2 & AIoMosi[i];
      dl_d[i]    = dl_we[i] ? AIoMosi[15:0] : dl_q[i];
      armed_d[i] = dl_we[i] | (armed_q[i] & ~hit_v[i]);
      exp_d[i]   = ~dl_we[i] & (hit_v[i] | (exp_q[i] & ~clr[i]));
    end
  end
  // state registers: reset wins over clock enable
  always_ff @(posedge AClkH) begin
    if (!AResetHN) begin
      ctrl_q  <= '0;
      irqen_q <= '0;
      dl_q    <= '0;
      armed_q <= '0;
      exp_q   <= '0;
      now_q   <= '0;
      scan_q  <= '0;
      irq_q   <= 1'b0;
    end else if (AClkHEn) begin
      ctrl_q  <= ctrl_d;
      irqen_q <= irqen_d;
      dl_q    <= dl_d;
      armed_q <= armed_d;
      exp_q   <= exp_d;
      now_q   <= now_d;
      scan_q  <= scan_d;
      irq_q   <= irq_d;
    end
  end
  assign AIrq  = irq_q & AResetHN;
  assign ATest = AResetHN ? {irq_q, tick, hit, scan_q, |armed_q, |exp_q, 1'b0} : 8'h00;
endmodule

// File: tb/tb_io_timer_sched.sv
// tb_io_timer_sched: scoreboard bench against a cycle-level behavioural model of the timer
module tb_io_timer_sched;
  localparam logic [15:0] BASE = 16'h0100;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n = 1'b0, en = 1'b1, s1m = 1'b0, s1k = 1'b0;
  logic [15:0] addr = '0;
  logic [3:0]  wsz = '0, rsz = '0;
  logic [63:0] mosi = '0, miso;
  logic        ack, err, irq;
  logic [7:0]  test;
  io_timer_sched #(.CAddrBase(BASE)) dut (
    .AClkH(clk), .AResetHN(rst_n), .AClkHEn(en), .AIoAddr(addr),
    .AIoWrSize(wsz), .AIoRdSize(rsz), .AIoMosi(mosi), .AIoMiso(miso),
    .AIoAddrAck(ack), .AIoAddrErr(err), .ASync1M(s1m), .ASync1K(s1k),
    .AIrq(irq), .ATest(test)
  );
  typedef struct {
    string       name;
    logic [63:0] miso;
    logic        ack, err, irq;
    bit          rd, chk_irq, chk_test;
  } exp_t;
  exp_t sbq[$];
  bit   probe = 0;
  int   checks = 0, failures = 0;
  logic [3:0] szs [7] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd15};
  logic [5:0]  m_ctrl;
  logic [3:0]  m_irqen, m_armed, m_exp;
  logic [15:0] m_dl [4];
  logic [15:0] m_now;
  int          m_scan;
  logic        m_irq;
  function automatic void mdec(input logic [15:0] a, input logic [3:0] s, output bit k, output bit e, output int o);
    bit inw;
    o   = int'(a) - int'(BASE);
    inw = o >= 0 && o <= 8;
    k   = inw && ((o <= 2 && s == 4'd1) || (o >= 4 && s == 4'd2));
    e   = inw && s != 0 && !k;
  endfunction
  function automatic logic [15:0] mreg(input int o);
    case (o)
      0: return {10'b0, m_ctrl};
      1: return {12'b0, m_irqen};
      2: return {8'b0, m_armed, m_exp};
      4, 5, 6, 7: return m_dl[o-4];
      8: return m_now;
      default: return 16'h0;
    endcase
  endfunction
  function automatic bit mhit();
    logic [15:0] df;
    df = m_now - m_dl[m_scan];
    return m_ctrl[m_scan] && m_armed[m_scan] && !df[15];
  endfunction
  task automatic mstep(input logic r, input logic e, input logic [15:0] a, input logic [3:0] ws, input logic [3:0] rs,
                       input logic [63:0] d, input logic p1m, input logic p1k);
    bit k, er, w, h, tk;
    int o, ch;
    logic [1:0] src;
    if (!r) begin
      m_ctrl = 0; m_irqen = 0; m_armed = 0; m_exp = 0; m_now = 0; m_scan = 0; m_irq = 0;
      for (int i = 0; i < 4; i++) m_dl[i] = 0;
    end else if (e) begin
      mdec(a, ws | rs, k, er, o);
      w   = k && ws != 0;
      h   = mhit();
      ch  = m_scan;
      src = m_ctrl[5:4];
      tk  = src == 3 || (src == 2 && p1m) || (src == 1 && p1k);
      m_irq  = |(m_exp & m_irqen);
      m_now  = src == 0 ? 16'd0 : m_now + 16'(tk);
      m_scan = (m_scan + 1) % 4;
      if (w && o == 2) m_exp = m_exp & ~d[3:0];
      if (h) begin m_armed[ch] = 0; m_exp[ch] = 1; end
      if (w && o >= 4 && o <= 7) begin m_dl[o-4] = d[15:0]; m_armed[o-4] = 1; m_exp[o-4] = 0; end
      if (w && o == 0) m_ctrl = d[5:0];
      if (w && o == 1) m_irqen = d[3:0];
    end
  endtask
  task automatic op(input logic r, input logic e, input logic [15:0] a, input logic [3:0] ws, input logic [3:0] rs,
                    input logic [63:0] d, input logic p1m, input logic p1k, input bit pr, input string nm);
    exp_t x;
    bit k, er;
    int o;
    rst_n = r; en = e; addr = a; wsz = ws; rsz = rs; mosi = d; s1m = p1m; s1k = p1k; probe = pr;
    if (rs != 0 || pr) begin
      mdec(a, ws | rs, k, er, o);
      x.name = nm; x.rd = rs != 0; x.ack = k; x.err = er;
      x.miso = (k && rs != 0) ? {48'b0, mreg(o)} : 64'b0;
      x.chk_irq = pr; x.irq = r ? m_irq : 1'b0; x.chk_test = pr && !r;
      sbq.push_back(x);
    end
    @(posedge clk);
    mstep(r, e, a, ws, rs, d, p1m, p1k);
    #1;
  endtask
  task automatic wr(input int o, input logic [3:0] s, input logic [63:0] d);
    op(1, 1, 16'(int'(BASE) + o), s, 0, d, 0, 0, 0, "wr");
  endtask
  task automatic rd(input int o, input logic [3:0] s, input string nm, input bit pr = 0);
    op(1, 1, 16'(int'(BASE) + o), 0, s, 0, 0, 0, pr, nm);
  endtask
  task automatic idle(input int n);
    repeat (n) op(1, 1, BASE, 0, 0, 0, 0, 0, 0, "");
  endtask
  task automatic wait_hit1();
    int n = 0;
    while (!(mhit() && m_scan == 1) && n < 64) begin idle(1); n++; end
    checks++;
    if (n >= 64) begin failures++; $display("FAIL wait_hit1 got=timeout exp=hit within 64 cycles"); end
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (rsz != 0 || probe) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard got=output with empty queue exp=queued entry");
      end else begin
        x = sbq.pop_front();
        if (x.rd) begin
          checks += 3;
          if (miso !== x.miso) begin failures++; $display("FAIL %s miso got=%h exp=%h", x.name, miso, x.miso); end
          if (ack !== x.ack) begin failures++; $display("FAIL %s ack got=%b exp=%b", x.name, ack, x.ack); end
          if (err !== x.err) begin failures++; $display("FAIL %s err got=%b exp=%b", x.name, err, x.err); end
        end
        if (x.chk_irq) begin
          checks++;
          if (irq !== x.irq) begin failures++; $display("FAIL %s irq got=%b exp=%b", x.name, irq, x.irq); end
        end
        if (x.chk_test) begin
          checks++;
          if (test !== 8'h00) begin failures++; $display("FAIL %s atest got=%h exp=00", x.name, test); end
        end
      end
    end
  end
  initial begin
    int n, o, kind;
    mstep(0, 1, 0, 0, 0, 0, 0, 0);
    op(0, 1, BASE, 0, 0, 0, 0, 0, 0, "");
    op(0, 1, BASE, 0, 0, 0, 0, 0, 1, "in_reset");
    idle(1);
    rd(0, 1, "rst_ctrl", 1); rd(2, 1, "rst_status"); rd(8, 2, "rst_now"); rd(4, 2, "rst_dl0");
    wr(0, 1, 64'h31); wr(1, 1, 64'h01); wr(4, 2, 64'd10);
    repeat (24) rd(2, 1, "single_status", 1);
    rd(8, 2, "single_now");
    wr(2, 1, 64'h01);
    repeat (3) rd(2, 1, "clear_status", 1);
    rd(0, 2, "dec_w0"); rd(8, 1, "dec_b8"); rd(8, 2, "dec_w8"); rd(9, 1, "dec_b9");
    rd(3, 1, "dec_hole"); rd(5, 4, "dec_dword"); rd(-1, 1, "dec_below"); rd(1, 0, "dec_nosize");
    rd(6, 2, "dec_dl2"); rd(0, 8, "dec_qword");
    for (int i = 0; i < 20; i++)
      op(1, 0, 16'(BASE + (i == 5 ? 16'd6 : 16'd8)), i == 5 ? 4'd2 : 4'd0, i == 5 ? 4'd0 : 4'd2,
         64'h1234, 0, 0, 0, "clken_now");
    rd(6, 2, "clken_dl2"); rd(2, 1, "clken_status"); rd(8, 2, "clken_now_after");
    wr(0, 1, 64'h32);
    wr(5, 2, 64'(m_now + 16'd3));
    wait_hit1();
    wr(5, 2, 64'(m_now + 16'd200));
    rd(2, 1, "sim_write_status"); rd(5, 2, "sim_write_dl1");
    wr(5, 2, 64'(m_now + 16'd3));
    wait_hit1();
    wr(2, 1, 64'h02);
    rd(2, 1, "sim_clear_status");
    wr(2, 1, 64'h0F);
    wr(0, 1, 64'h31);
    n = 0;
    while (m_now != 16'hFFF0 && n < 70000) begin idle(1); n++; end
    checks++;
    if (m_now != 16'hFFF0) begin failures++; $display("FAIL wrap_reach got=%h exp=fff0", m_now); end
    wr(4, 2, 64'h0002);
    repeat (28) rd(2, 1, "wrap_status", 1);
    rd(8, 2, "wrap_now");
    for (int i = 0; i < 700; i++) begin
      kind = $urandom_range(0, 9);
      o    = $urandom_range(0, 12) - 2;
      case (kind)
        0: op(1, $urandom_range(0, 7) != 0, BASE, 1, 0, 64'($urandom), $urandom, $urandom, 0, "");
        1: op(1, 1, 16'(BASE + 16'd1), 1, 0, 64'($urandom), 0, 0, 0, "");
        2: op(1, $urandom_range(0, 7) != 0, 16'(BASE + 16'(4 + $urandom_range(0, 3))), 2, 0,
              64'(m_now + 16'($urandom_range(0, 40))), $urandom, $urandom, 0, "");
        3: op(1, 1, 16'(BASE + 16'd2), 1, 0, 64'($urandom), $urandom, $urandom, 0, "");
        4, 5, 6: op(1, $urandom_range(0, 7) != 0, 16'(int'(BASE) + o), 0, szs[$urandom_range(0, 6)],
                    {$urandom, $urandom}, $urandom, $urandom, $urandom_range(0, 1), "rand_rd");
        7: op($urandom_range(0, 60) != 0, 1, BASE, 0, 0, 0, 0, 0, 1, "rand_probe");
        default: op(1, $urandom_range(0, 7) != 0, 16'(int'(BASE) + o), 0, 2, 0, $urandom, $urandom, 0, "rand_rd2");
      endcase
    end
    wr(0, 1, 64'h3F); wr(1, 1, 64'h0F);
    for (int i = 0; i < 4; i++) wr(4 + i, 2, 64'(m_now + 16'd1000));
    wr(4, 2, 64'(m_now)); idle(6);
    rd(2, 1, "pre_reset_status", 1);
    op(0, 1, BASE, 0, 0, 0, 0, 0, 1, "reset_mid");
    op(0, 1, BASE, 0, 0, 0, 0, 0, 1, "reset_held");
    rd(2, 1, "post_reset_status", 1); rd(8, 2, "post_reset_now"); rd(0, 1, "post_reset_ctrl"); rd(7, 2, "post_reset_dl3");
    idle(20);
    rd(2, 1, "post_reset_idle", 1);
    probe = 0; rsz = 0;
    idle(2);
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL drain got=%0d exp=0", sbq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_timer_sched.md
IO_TIMER_SCHED -- requirements
Module: io_timer_sched

Interface
REQ-001 SHALL have parameter CAddrBase, default 16'h0000, meaning the base address of the register window (+0..+8).
REQ-002 SHALL have port AClkH  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port AResetHN  in  1  reset; synchronous, active-low.
REQ-004 SHALL have port AClkHEn  in  1  clock enable; when 0, all state holds and IO writes are ignored.
REQ-005 SHALL have port AIoAddr  in  16  IO byte address.
REQ-006 SHALL have ports AIoWrSize and AIoRdSize  in  4 each  one-hot access size: bit0 byte, bit1 word, bit2 dword, bit3 qword; 0 means no access.
REQ-007 SHALL have port AIoMosi  in  64  write data, LSB-aligned.
REQ-008 SHALL have port AIoMiso  out  64  read data, LSB-aligned, zero-extended, all-zero when there is no valid read.
REQ-009 SHALL have ports AIoAddrAck and AIoAddrErr  out  1 each  combinational decode result.
REQ-010 SHALL have ports ASync1M and ASync1K  in  1 each  single-cycle tick pulses.
REQ-011 SHALL have port AIrq  out  1  registered interrupt.
REQ-012 SHALL have port ATest  out  8  debug: {FIrq, BTick, BHit, FScan[1:0], |FArmed, |FExp, 1'b0}.

Function
REQ-013 SHALL provide this register map:
- +0 byte Ctrl R/W: [5:4] tick source (11=CLK, 10=1M, 01=1K, 00=off); [3:0] channel enable; [7:6] RFU, read 0.
- +1 byte IrqEn R/W: [3:0] per-channel interrupt enable.
- +2 byte Status: read [3:0]=FExp, [7:4]=FArmed; write 1 to a bit of [3:0] clears that FExp bit.
- +4..+7 word Deadline[0..3]: R/W; a write arms the channel.
- +8 word Now: read-only; writes are acked and ignored.
REQ-014 SHALL decode access this way:
- Ack: address in the map with the matching size (byte for +0..+2, word for +4..+8).
- Err: address in the window CAddrBase..CAddrBase+8 with a wrong size, or a hole (+3).
- Neither Ack nor Err: address outside the window, or no size asserted.
REQ-015 SHALL generate BTick from the tick source: every enabled cycle for CLK, ASync1M for 1M, ASync1K for 1K, never for off.
REQ-016 SHALL keep a 16-bit timebase FNow:
- +1 on each BTick, wrapping 0xFFFF to 0x0000.
- Forced to 0 while the tick source is off.
REQ-017 SHALL time-share one comparator using a 2-bit round-robin pointer FScan, which advances 0,1,2,3,0 every enabled cycle regardless of channel state.
REQ-018 SHALL assert BHit for channel FScan when all of the following hold: the channel is enabled, FArmed[FScan]=1, and bit 15 of (FNow - Deadline[FScan]) mod 2^16 is 0 (deadline reached or passed, wrap-safe).
REQ-019 SHALL run a per-channel state machine:
- IDLE (Armed=0, Exp=0) to ARMED on a Deadline write.
- ARMED to EXPIRED (Armed=0, Exp=1) on BHit.
- EXPIRED to IDLE on a Status write-1-clear.
- EXPIRED to ARMED on a Deadline write, which also clears Exp.
REQ-020 SHALL leave a disabled channel's state frozen; disabling a channel does not clear Armed.
REQ-021 SHALL resolve a Deadline write and BHit on the same channel in the same cycle in favour of the write: the channel becomes ARMED with the new deadline, and the hit is discarded.
REQ-022 SHALL resolve a Status clear and BHit on the same channel in the same cycle in favour of the hit: Exp=1.
REQ-023 SHALL set FExp at most 4 enabled cycles after the cycle in which FNow first satisfies REQ-018.
REQ-024 SHALL register FIrq as |(FExp & IrqEn[3:0]), updated the cycle after FExp changes; AIrq = FIrq.
REQ-025 SHALL make a read return the current register value with zero latency.

Reset
REQ-026 SHALL, on AResetHN=0 at a rising AClkH edge, clear the following to 0 regardless of AClkHEn: Ctrl, IrqEn, Deadline[0..3], FArmed, FExp, FNow, FScan, FIrq.
REQ-027 SHALL, while in reset, drive AIrq=0 and ATest=0; AIoMiso is 0 unless a read is decoded.
REQ-028 SHALL abandon any armed channel when reset is applied mid-operation; channels stay IDLE after release until a new Deadline write.

Verification
REQ-029 SHALL verify single expiry:
- Stimulus: Ctrl=0x31, IrqEn=0x01, Deadline0=10.
- Response: Status bit0 is set within 4 cycles after Now=10; AIrq=1 one cycle later; writing 0x01 to Status drops AIrq the next cycle.
REQ-030 SHALL verify wrap-around:
- Stimulus: Deadline0=0x0002 written when Now=0xFFF0.
- Response: expiry only after Now wraps to 0x0002, not at Now=0xFFF0.
REQ-031 SHALL verify the simultaneous-event rules:
- A Deadline1 write in the BHit cycle for channel 1: the channel stays ARMED and Exp1=0.
- A Status clear in the BHit cycle for channel 1: Exp1=1.
REQ-032 SHALL verify decode:
- A word read at +0 gives AIoAddrErr=1 and AIoMiso=0.
- A byte read at +8 gives AIoAddrErr=1.
- A word read at +8 gives Ack=1 and returns Now.
- A byte access at +9 gives Ack=0 and Err=0.
REQ-033 SHALL verify clock enable and reset:
- Holding AClkHEn=0 for 20 cycles freezes FNow/FScan, and a Deadline write in that window has no effect.
- Asserting AResetHN=0 with 4 channels armed gives all state 0 and AIrq=0 the next edge.
